// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multi-cycle MiniMIPS main control: opcodes,
// FSM state encoding, ALUop values and trap causes.
package multicycle_main_control_pkg;

    // Opcode map; everything above OP_SW is illegal.
    localparam int OP_R    = 0;
    localparam int OP_ADDI = 1;
    localparam int OP_ANDI = 2;
    localparam int OP_ORI  = 3;
    localparam int OP_NORI = 4;
    localparam int OP_BEQ  = 5;
    localparam int OP_BNE  = 6;
    localparam int OP_SLTI = 7;
    localparam int OP_LW   = 8;
    localparam int OP_SW   = 9;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    localparam logic [1:0] CAUSE_NONE       = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b01;
    localparam logic [1:0] CAUSE_FETCH_TO   = 2'b10;
    localparam logic [1:0] CAUSE_MEM_TO     = 2'b11;

endpackage

// File: rtl/multicycle_main_control_mem_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_ready. expired flags the
// waiting cycle that hits the limit, so the FSM can leave on that same edge.
module multicycle_main_control_mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_reg;

    // Wait-cycle counter; clear has priority over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // This waiting cycle is the TIMEOUT_CYCLES-th one.
    assign expired = enable && (count_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_main_control.sv
// Multi-cycle MiniMIPS main control: Moore FSM sequencing fetch, decode,
// execute, memory and writeback against a shared memory port, with a
// memory-wait watchdog, illegal-opcode trap and retired-instruction counter.
module multicycle_main_control
    import multicycle_main_control_pkg::*;
#(
    parameter int OPCODE_W       = 4,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                Branch,
    output logic                Branchne,
    output logic                RegDst,
    output logic                ALUSrc,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic [1:0]          ALUop,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [CNT_W-1:0]    retired_count
);

    state_t              state_reg, state_next;
    logic [OPCODE_W-1:0] opcode_reg;
    logic [1:0]          trap_cause_reg, trap_cause_next;
    logic [CNT_W-1:0]    retired_count_reg;
    logic                retire;

    logic timer_enable, timer_clear, timer_expired;

    logic is_r, is_alu_imm, is_beq, is_bne, is_lw, is_sw, is_branch, is_mem, is_legal;

    // Decode of the latched opcode.
    always_comb begin
        is_r       = (opcode_reg == OPCODE_W'(OP_R));
        is_beq     = (opcode_reg == OPCODE_W'(OP_BEQ));
        is_bne     = (opcode_reg == OPCODE_W'(OP_BNE));
        is_lw      = (opcode_reg == OPCODE_W'(OP_LW));
        is_sw      = (opcode_reg == OPCODE_W'(OP_SW));
        is_alu_imm = (opcode_reg == OPCODE_W'(OP_ADDI)) || (opcode_reg == OPCODE_W'(OP_ANDI)) ||
                     (opcode_reg == OPCODE_W'(OP_ORI))  || (opcode_reg == OPCODE_W'(OP_NORI)) ||
                     (opcode_reg == OPCODE_W'(OP_SLTI));
        is_branch  = is_beq || is_bne;
        is_mem     = is_lw || is_sw;
        is_legal   = (opcode_reg <= OPCODE_W'(OP_SW));
    end

    // The watchdog runs only while an access is outstanding and unanswered;
    // any completed access or non-memory state restarts it from zero.
    assign timer_enable = ((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !mem_ready;
    assign timer_clear  = !timer_enable;

    multicycle_main_control_mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_mem_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    // State, latched opcode, trap cause and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= ST_START;
            opcode_reg        <= '0;
            trap_cause_reg    <= CAUSE_NONE;
            retired_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            trap_cause_reg <= trap_cause_next;
            if ((state_reg == ST_FETCH) && mem_ready) begin
                opcode_reg <= opcode;
            end
            if (retire) begin
                retired_count_reg <= retired_count_reg + CNT_W'(1);
            end
        end
    end

    // Next-state and control outputs; mem_ready only qualifies the
    // FETCH/MEM completion paths.
    always_comb begin
        state_next      = state_reg;
        trap_cause_next = trap_cause_reg;
        retire          = 1'b0;
        mem_req         = 1'b0;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        IRWrite         = 1'b0;
        PCWrite         = 1'b0;
        Branch          = 1'b0;
        Branchne        = 1'b0;
        RegDst          = 1'b0;
        ALUSrc          = 1'b0;
        MemtoReg        = 1'b0;
        RegWrite        = 1'b0;
        ALUop           = ALUOP_ADD;

        case (state_reg)
            ST_START: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = ST_DECODE;
                end else if (timer_expired) begin
                    state_next      = ST_TRAP;
                    trap_cause_next = CAUSE_FETCH_TO;
                end
            end
            ST_DECODE: begin
                if (is_legal) begin
                    state_next = ST_EXEC;
                end else begin
                    state_next      = ST_TRAP;
                    trap_cause_next = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                ALUSrc   = is_alu_imm || is_mem;
                Branch   = is_beq;
                Branchne = is_bne;
                if (is_r) begin
                    ALUop = ALUOP_RTYPE;
                end else if (is_branch) begin
                    ALUop = ALUOP_BRANCH;
                end
                if (is_branch) begin
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end else if (is_mem) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                MemRead  = is_lw;
                MemWrite = is_sw;
                ALUSrc   = 1'b1;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_next = ST_WB;
                    end else begin
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end
                end else if (timer_expired) begin
                    state_next      = ST_TRAP;
                    trap_cause_next = CAUSE_MEM_TO;
                end
            end
            ST_WB: begin
                RegWrite   = 1'b1;
                RegDst     = is_r;
                MemtoReg   = is_lw;
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                state_next = ST_TRAP;
            end
            default: begin
                state_next = ST_START;
            end
        endcase
    end

    assign trap          = (state_reg == ST_TRAP);
    assign trap_cause    = trap_cause_reg;
    assign retired_count = retired_count_reg;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: a transaction-level model expands each
// instruction into its expected per-cycle trace, a table of directed cases
// checks latency/cause/IR loads, then a hand sequence and random traffic.
`timescale 1ns/1ps
module tb_multicycle_main_control;

    localparam int TIMEOUT_CYCLES = 15;
    localparam int CNT_W          = 4;   // narrow so the random run wraps the counter

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       opcode;
    logic             mem_ready;
    logic             mem_req, MemRead, MemWrite, IRWrite, PCWrite, Branch, Branchne;
    logic             RegDst, ALUSrc, MemtoReg, RegWrite, trap;
    logic [1:0]       ALUop, trap_cause;
    logic [CNT_W-1:0] retired_count;
    logic [15:0]      dut_outs;

    multicycle_main_control #(
        .OPCODE_W(4), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .Branchne(Branchne),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUop(ALUop), .trap(trap), .trap_cause(trap_cause), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    assign dut_outs = {mem_req, MemRead, MemWrite, IRWrite, PCWrite, Branch, Branchne,
                       RegDst, ALUSrc, MemtoReg, RegWrite, ALUop, trap, trap_cause};

    typedef struct {
        logic             ready;
        logic [3:0]       op;
        logic [15:0]      outs;
        logic [CNT_W-1:0] count;
    } cyc_t;

    typedef struct {
        logic [3:0] op;
        int         fw;
        int         mw;
        int         lat;
        logic [1:0] cause;
        int         irw;
    } vec_t;

    cyc_t q[$];
    vec_t tbl[14];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // model state
    logic [CNT_W-1:0] m_count;
    logic             m_trapped;
    int               m_trap_len;

    // per-case observation
    logic             track;
    logic             seen;
    int               ev_cyc;
    int               irw_n;
    int               t0;

    function automatic logic [15:0] pack(input logic req, rd, wr, irw, pcw, br, brne,
                                         rdst, asrc, m2r, rw, input logic [1:0] aop,
                                         input logic tr, input logic [1:0] cause);
        return {req, rd, wr, irw, pcw, br, brne, rdst, asrc, m2r, rw, aop, tr, cause};
    endfunction

    function automatic logic [3:0] junk_op();
        return 4'($urandom);
    endfunction

    task automatic push(input logic rdy, input logic [3:0] op, input logic [15:0] o);
        cyc_t c;
        c.ready = rdy;
        c.op    = op;
        c.outs  = o;
        c.count = m_count;
        q.push_back(c);
    endtask

    task automatic enter_trap(input logic [1:0] cause);
        m_trapped = 1'b1;
        for (int i = 0; i < m_trap_len; i++)
            push(1'($urandom), junk_op(), pack(0,0,0,0,0,0,0,0,0,0,0,2'b00,1,cause));
    endtask

    // One memory access: 'waits' not-ready cycles, then the completing cycle,
    // unless the wait count reaches the timeout first.
    task automatic access(input int waits, input logic [3:0] op_done, input logic [15:0] o_wait,
                          input logic [15:0] o_done, input logic [1:0] cause, output logic ok);
        ok = 1'b1;
        for (int k = 1; k <= waits; k++) begin
            push(1'b0, junk_op(), o_wait);
            if (k == TIMEOUT_CYCLES) begin
                enter_trap(cause);
                ok = 1'b0;
                return;
            end
        end
        push(1'b1, op_done, o_done);
    endtask

    // Expand one instruction into its expected cycle trace.
    task automatic push_instr(input logic [3:0] op, input int fw, input int mw);
        logic       ok;
        logic       is_r, br, mem, asrc;
        logic [1:0] aop;
        if (m_trapped) return;
        access(fw, op, pack(1,1,0,0,0,0,0,0,0,0,0,2'b00,0,2'b00),
                       pack(1,1,0,1,1,0,0,0,0,0,0,2'b00,0,2'b00), 2'b10, ok);
        if (!ok) return;
        push(1'($urandom), junk_op(), 16'h0000);            // decode
        if (op > 4'd9) begin
            enter_trap(2'b01);
            return;
        end
        is_r = (op == 4'd0);
        br   = (op == 4'd5) || (op == 4'd6);
        mem  = (op == 4'd8) || (op == 4'd9);
        asrc = (op >= 4'd1 && op <= 4'd4) || op >= 4'd7;
        aop  = is_r ? 2'b10 : (br ? 2'b01 : 2'b00);
        push(1'($urandom), junk_op(),
             pack(0,0,0,0,0, op == 4'd5, op == 4'd6, 0, asrc, 0, 0, aop, 0, 2'b00));
        if (br) begin
            m_count++;
            return;
        end
        if (mem) begin
            access(mw, junk_op(), pack(1, op == 4'd8, op == 4'd9, 0,0,0,0,0,1,0,0,2'b00,0,2'b00),
                                  pack(1, op == 4'd8, op == 4'd9, 0,0,0,0,0,1,0,0,2'b00,0,2'b00),
                                  2'b11, ok);
            if (!ok) return;
            if (op == 4'd9) begin
                m_count++;
                return;
            end
        end
        push(1'($urandom), junk_op(), pack(0,0,0,0,0,0,0, is_r, 0, op == 4'd8, 1, 2'b00, 0, 2'b00));
        m_count++;
    endtask

    // Apply up to n queued cycles, comparing outputs 1 ns after driving.
    task automatic run_queue(input int n);
        for (int i = 0; i < n && q.size() > 0; i++) begin
            cyc_t c;
            c = q.pop_front();
            mem_ready = c.ready;
            opcode    = c.op;
            #1;
            checks++;
            if (dut_outs !== c.outs) begin
                errors++;
                $display("FAIL outs cyc=%0d got=%h want=%h", cyc, dut_outs, c.outs);
            end
            checks++;
            if (retired_count !== c.count) begin
                errors++;
                $display("FAIL count cyc=%0d got=%0d want=%0d", cyc, retired_count, c.count);
            end
            $display("cyc %0d rdy=%b op=%h outs=%h cnt=%0d", cyc, c.ready, c.op, dut_outs, retired_count);
            if (track && !seen && (trap || retired_count != '0)) begin
                seen   = 1'b1;
                ev_cyc = cyc;
            end
            if (track && !seen && IRWrite) irw_n++;
            cyc++;
            @(negedge clk);
        end
    endtask

    // Assert reset now (possibly mid-cycle), check the cleared state, release
    // on the next falling edge and queue the START cycle.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (dut_outs !== 16'h0000 || retired_count !== '0) begin
            errors++;
            $display("FAIL reset outs=%h cnt=%0d want outs=0000 cnt=0", dut_outs, retired_count);
        end
        @(negedge clk);
        reset     = 1'b0;
        m_count   = '0;
        m_trapped = 1'b0;
        q.delete();
        push(1'($urandom), junk_op(), 16'h0000);
    endtask

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b0;
        opcode    = 4'd0;
        track     = 1'b0;
        seen      = 1'b0;
        ev_cyc    = 0;
        irw_n     = 0;
        t0        = 0;
        m_count   = '0;
        m_trapped = 1'b0;
        m_trap_len = 20;

        // op, fetch waits, mem waits, cycles to retire/trap, final cause, IR loads
        tbl[0]  = '{4'd1,  0,  0,  4, 2'b00, 1};   // addi
        tbl[1]  = '{4'd8,  2,  3, 10, 2'b00, 1};   // lw with waits
        tbl[2]  = '{4'd5,  0,  0,  3, 2'b00, 1};   // beq
        tbl[3]  = '{4'd6,  0,  0,  3, 2'b00, 1};   // bne
        tbl[4]  = '{4'd0,  0,  0,  4, 2'b00, 1};   // R-type
        tbl[5]  = '{4'd9,  0,  0,  4, 2'b00, 1};   // sw
        tbl[6]  = '{4'd8,  0,  0,  5, 2'b00, 1};   // lw
        tbl[7]  = '{4'd12, 0,  0,  2, 2'b01, 1};   // illegal 1100
        tbl[8]  = '{4'd9,  0, 20, 18, 2'b11, 1};   // sw memory timeout
        tbl[9]  = '{4'd9,  0, 14, 18, 2'b00, 1};   // sw ready on 15th wait cycle
        tbl[10] = '{4'd1, 20,  0, 15, 2'b10, 0};   // fetch timeout
        tbl[11] = '{4'd1, 14,  0, 18, 2'b00, 1};   // fetch ready on 15th cycle
        tbl[12] = '{4'd15, 0,  0,  2, 2'b01, 1};   // illegal 1111
        tbl[13] = '{4'd10, 0,  0,  2, 2'b01, 1};   // illegal 1010

        #2;
        for (int i = 0; i < 14; i++) begin
            m_trap_len = 20;
            do_reset();
            run_queue(1);
            seen  = 1'b0;
            irw_n = 0;
            t0    = cyc;
            track = 1'b1;
            push_instr(tbl[i].op, tbl[i].fw, tbl[i].mw);
            push_instr(4'd1, 0, 0);
            run_queue(1000);
            track = 1'b0;
            checks++;
            if (!seen || (ev_cyc - t0) != tbl[i].lat) begin
                errors++;
                $display("FAIL latency case=%0d seen=%0b got=%0d want=%0d", i, seen, ev_cyc - t0, tbl[i].lat);
            end
            checks++;
            if (trap_cause !== tbl[i].cause) begin
                errors++;
                $display("FAIL cause case=%0d got=%b want=%b", i, trap_cause, tbl[i].cause);
            end
            checks++;
            if (irw_n != tbl[i].irw) begin
                errors++;
                $display("FAIL irwrite case=%0d got=%0d want=%0d", i, irw_n, tbl[i].irw);
            end
        end

        // Reset mid-MEM of a lw after one retired addi.
        m_trap_len = 3;
        do_reset();
        push_instr(4'd1, 0, 0);
        push_instr(4'd8, 0, 5);
        run_queue(9);                 // START, addi, lw fetch/decode/exec, first MEM wait
        mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || MemRead !== 1'b1 || retired_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL midmem req=%b rd=%b cnt=%0d want req=1 rd=1 cnt=1", mem_req, MemRead, retired_count);
        end
        #2;
        do_reset();
        push_instr(4'd8, 0, 0);
        push_instr(4'd6, 0, 0);
        run_queue(1000);

        // Random traffic against the model.
        do_reset();
        run_queue(1);
        for (int n = 0; n < 80; n++) begin
            logic [3:0] r_op;
            int         r_fw, r_mw, r_sel;
            r_sel = int'($urandom_range(0, 19));
            r_op  = (r_sel == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            r_fw  = (r_sel == 1) ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 3));
            r_mw  = (r_sel == 2) ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 3));
            push_instr(r_op, r_fw, r_mw);
            run_queue(1000);
            if (m_trapped) begin
                do_reset();
                run_queue(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
